// File: rtl/instr_encoder_if.sv
// Field-in / instruction-word-out bundle for instr_encoder; master is the program generator side.
interface instr_encoder_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [2:0]        in_f3;
  logic              in_alt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_base;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic              err_flag;
  logic              err_clr;

  modport master (
    output in_valid, in_kind, in_f3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    output addr_load, addr_base, out_ready, err_clr,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_flag
  );

  modport slave (
    input  in_valid, in_kind, in_f3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    input  addr_load, addr_base, out_ready, err_clr,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_flag
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded fields into RV32I words with byte addresses; 2-stage valid/ready pipe, 1 beat/clk,
// out_* held while stalled. ENC_DROP_ILLEGAL_EN: discard illegal beats instead of emitting a NOP.
module instr_encoder #(
  parameter int ADDR_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [3:0] K_LOAD   = 4'd0;
  localparam logic [3:0] K_OPIMM  = 4'd1;
  localparam logic [3:0] K_AUIPC  = 4'd2;
  localparam logic [3:0] K_STORE  = 4'd3;
  localparam logic [3:0] K_OP     = 4'd4;
  localparam logic [3:0] K_LUI    = 4'd5;
  localparam logic [3:0] K_BRANCH = 4'd6;
  localparam logic [3:0] K_JALR   = 4'd7;
  localparam logic [3:0] K_JAL    = 4'd8;

`ifdef ENC_DROP_ILLEGAL_EN
  localparam bit DROP_ILLEGAL = 1'b1;
`else
  localparam bit DROP_ILLEGAL = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } beat_t;

  beat_t             s1_q, s1_d;
  logic              s1_v_q, s1_v_d;
  logic              s2_v_q, s2_v_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              errf_q, errf_d;

  logic              s1_move;
  logic              s2_take;
  logic              in_fire;
  logic [31:0]       enc;
  logic              illegal;
  logic              i_ok, b_ok, j_ok, is_shift;
  logic [ADDR_W-1:0] base_al;
  logic [ADDR_W-1:0] beat_addr;

  assign s1_move      = s1_v_q & (~s2_v_q | bus.out_ready);
  assign bus.in_ready = ~s1_v_q | s1_move;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign s2_take      = s1_move & ~(DROP_ILLEGAL & illegal);

  assign base_al   = {bus.addr_base[ADDR_W-1:2], 2'b00};
  assign beat_addr = bus.addr_load ? base_al : cnt_q;

  // Range checks: sign-extension bits must all agree with the top bit of the field.
  assign i_ok     = (&s1_q.imm[31:11]) | ~(|s1_q.imm[31:11]);
  assign b_ok     = ((&s1_q.imm[31:12]) | ~(|s1_q.imm[31:12])) & ~s1_q.imm[0];
  assign j_ok     = ((&s1_q.imm[31:20]) | ~(|s1_q.imm[31:20])) & ~s1_q.imm[0];
  assign is_shift = (s1_q.f3 == 3'b001) | (s1_q.f3 == 3'b101);

  always_comb begin
    enc     = '0;
    illegal = 1'b0;
    case (s1_q.kind)
      K_LOAD: begin
        enc     = {s1_q.imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, OP_LOAD};
        illegal = ~i_ok | (s1_q.f3 == 3'b011) | (s1_q.f3[2:1] == 2'b11);
      end
      K_OPIMM: begin
        if (is_shift) begin
          enc     = {1'b0, s1_q.alt, 5'b00000, s1_q.imm[4:0], s1_q.rs1, s1_q.f3, s1_q.rd, OP_OPIMM};
          illegal = (|s1_q.imm[31:5]) | (s1_q.alt & ~s1_q.f3[2]);
        end else begin
          enc     = {s1_q.imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, OP_OPIMM};
          illegal = ~i_ok | s1_q.alt;
        end
      end
      K_AUIPC: begin
        enc     = {s1_q.imm[31:12], s1_q.rd, OP_AUIPC};
        illegal = |s1_q.imm[11:0];
      end
      K_STORE: begin
        enc     = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.imm[4:0], OP_STORE};
        illegal = ~i_ok | (s1_q.f3 > 3'b010);
      end
      K_OP: begin
        enc     = {1'b0, s1_q.alt, 5'b00000, s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.rd, OP_OP};
        illegal = s1_q.alt & ~((s1_q.f3 == 3'b000) | (s1_q.f3 == 3'b101));
      end
      K_LUI: begin
        enc     = {s1_q.imm[31:12], s1_q.rd, OP_LUI};
        illegal = |s1_q.imm[11:0];
      end
      K_BRANCH: begin
        enc     = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.f3,
                   s1_q.imm[4:1], s1_q.imm[11], OP_BRANCH};
        illegal = ~b_ok | (s1_q.f3[2:1] == 2'b01);
      end
      K_JALR: begin
        enc     = {s1_q.imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, OP_JALR};
        illegal = ~i_ok | (|s1_q.f3);
      end
      K_JAL: begin
        enc     = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12], s1_q.rd, OP_JAL};
        illegal = ~j_ok;
      end
      default: begin
        enc     = '0;
        illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_d    = s1_q;
    s2_v_d  = s2_v_q;
    instr_d = instr_q;
    oaddr_d = oaddr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    errf_d  = errf_q;

    if (in_fire) begin
      s1_v_d = 1'b1;
      s1_d   = '{kind: bus.in_kind, f3: bus.in_f3, alt: bus.in_alt, rd: bus.in_rd,
                 rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};
    end else if (s1_move) begin
      s1_v_d = 1'b0;
    end

    // A dropped beat still leaves S1, so S2 drains as if nothing arrived.
    if (s2_take) begin
      s2_v_d  = 1'b1;
      instr_d = illegal ? NOP : enc;
      oaddr_d = beat_addr;
      err_d   = illegal;
      cnt_d   = beat_addr + ADDR_W'(4);
    end else begin
      if (bus.out_ready) s2_v_d = 1'b0;
      if (bus.addr_load) cnt_d = base_al;
    end

    if (s1_move & illegal) errf_d = 1'b1;
    else if (bus.err_clr)  errf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s1_q    <= '0;
      s2_v_q  <= 1'b0;
      instr_q <= '0;
      oaddr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      errf_q  <= 1'b0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_q    <= s1_d;
      s2_v_q  <= s2_v_d;
      instr_q <= instr_d;
      oaddr_q <= oaddr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      errf_q  <= errf_d;
    end
  end

  assign bus.out_valid = s2_v_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = oaddr_q;
  assign bus.out_err   = err_q & ~DROP_ILLEGAL;
  assign bus.err_flag  = errf_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboarded bench for instr_encoder: directed spec cases plus randomized beats against a field-arithmetic model.
module tb_instr_encoder;
  localparam int AW = 16;

`ifdef ENC_DROP_ILLEGAL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct {
    logic [31:0]   w;
    logic [AW-1:0] a;
    logic          e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(AW)) bus();
  instr_encoder #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t          sbq[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_acc = 0;
  int            rdy_mode = 0;
  logic [AW-1:0] m_cnt = '0;
  bit            m_err = 1'b0;

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Reference: builds each word by shifting field values into place.
  function automatic void ref_enc(input logic [3:0] k, input logic [2:0] f3, input logic a,
                                  input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [31:0] imm, output logic [31:0] w, output bit ill);
    int si;
    bit irng;
    logic [31:0] R, F, S1, S2, Ifld;
    si   = $signed(imm);
    irng = (si >= -2048) && (si <= 2047);
    R    = 32'(rd) << 7;
    F    = 32'(f3) << 12;
    S1   = 32'(rs1) << 15;
    S2   = 32'(rs2) << 20;
    Ifld = (imm & 32'hFFF) << 20;
    w    = '0;
    ill  = 1'b0;
    case (k)
      4'd0: begin w = 32'h03 | R | F | S1 | Ifld; ill = !irng || f3 == 3'd3 || f3 >= 3'd6; end
      4'd1: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          w   = 32'h13 | R | F | S1 | ((imm & 32'd31) << 20) | (32'(a) << 30);
          ill = (imm > 32'd31) || (a && f3 == 3'd1);
        end else begin
          w   = 32'h13 | R | F | S1 | Ifld;
          ill = !irng || a;
        end
      end
      4'd2: begin w = 32'h17 | R | (imm & 32'hFFFFF000); ill = (imm & 32'hFFF) != 32'd0; end
      4'd3: begin
        w   = 32'h23 | ((imm & 32'd31) << 7) | F | S1 | S2 | (((imm >> 5) & 32'd127) << 25);
        ill = !irng || f3 > 3'd2;
      end
      4'd4: begin w = 32'h33 | R | F | S1 | S2 | (32'(a) << 30); ill = a && !(f3 == 3'd0 || f3 == 3'd5); end
      4'd5: begin w = 32'h37 | R | (imm & 32'hFFFFF000); ill = (imm & 32'hFFF) != 32'd0; end
      4'd6: begin
        w = 32'h63 | (((imm >> 11) & 32'd1) << 7) | (((imm >> 1) & 32'd15) << 8) | F | S1 | S2 |
            (((imm >> 5) & 32'd63) << 25) | (((imm >> 12) & 32'd1) << 31);
        ill = si < -4096 || si > 4094 || imm[0] || f3 == 3'd2 || f3 == 3'd3;
      end
      4'd7: begin w = 32'h67 | R | F | S1 | Ifld; ill = !irng || f3 != 3'd0; end
      4'd8: begin
        w = 32'h6F | R | (((imm >> 12) & 32'd255) << 12) | (((imm >> 11) & 32'd1) << 20) |
            (((imm >> 1) & 32'd1023) << 21) | (((imm >> 20) & 32'd1) << 31);
        ill = si < -1048576 || si > 1048574 || imm[0];
      end
      default: ill = 1'b1;
    endcase
    if (ill) w = 32'h13;
  endfunction

  task automatic send(input logic [3:0] k, input logic [2:0] f3, input logic a, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] w, input bit ill);
    bit done = 1'b0;
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_kind = k; bus.in_f3 = f3; bus.in_alt = a;
    bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    while (!done) begin
      #1;
      if (bus.in_ready) begin
        done = 1'b1;
        n_acc++;
        if (!(DROP && ill)) begin
          sbq.push_back('{w, m_cnt, ill});
          m_cnt += AW'(4);
        end
        if (ill) m_err = 1'b1;
      end
      @(posedge clk);
      if (!done) begin
        t++;
        if (t > 200) begin fail_now("send_accept"); done = 1'b1; end
        else @(negedge clk);
      end
    end
  endtask

  task automatic send_m(input logic [3:0] k, input logic [2:0] f3, input logic a, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    bit ill;
    ref_enc(k, f3, a, rd, rs1, rs2, imm, w, ill);
    send(k, f3, a, rd, rs1, rs2, imm, w, ill);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); bus.in_valid = 1'b0; end
  endtask

  task automatic drain();
    int t = 0;
    idle(1);
    while ((sbq.size() != 0 || bus.out_valid) && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) fail_now("drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic load_addr(input logic [AW-1:0] base);
    @(negedge clk); bus.addr_load = 1'b1; bus.addr_base = base;
    @(negedge clk); bus.addr_load = 1'b0;
    m_cnt = base & ~AW'(3);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on each handshake; checks outputs hold while stalled.
  initial begin
    bit   stall = 1'b0;
    exp_t held, e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin stall = 1'b0; continue; end
      if (stall) begin
        chk_eq("hold_valid", 32'(bus.out_valid), 32'd1);
        chk_eq("hold_instr", bus.out_instr, held.w);
        chk_eq("hold_addr", 32'(bus.out_addr), 32'(held.a));
      end
      stall = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (sbq.size() == 0) fail_now("unexpected_word");
          else begin
            e = sbq.pop_front();
            chk_eq("instr", bus.out_instr, e.w);
            chk_eq("addr", 32'(bus.out_addr), 32'(e.a));
            chk_eq("out_err", 32'(bus.out_err), 32'(e.e));
          end
        end else begin
          stall = 1'b1;
          held  = '{bus.out_instr, bus.out_addr, bus.out_err};
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  k;
    logic [31:0] imm;
    bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_f3 = '0; bus.in_alt = 1'b0;
    bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    bus.addr_load = 1'b0; bus.addr_base = '0; bus.err_clr = 1'b0; bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #2;
    chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("rst_out_instr", bus.out_instr, 32'd0);
    chk_eq("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk_eq("rst_out_err", 32'(bus.out_err), 32'd0);
    chk_eq("rst_err_flag", 32'(bus.err_flag), 32'd0);
    chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // ADDI x1,x0,5 with latency check
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0; #2;
    chk_eq("lat_after_accept", 32'(bus.out_valid), 32'd0);
    @(negedge clk); #2;
    chk_eq("lat_next_edge", 32'(bus.out_valid), 32'd1);
    drain();

    load_addr('0);
    send(4'd4, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0);
    send(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send(4'd6, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0);
    send(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b0);
    drain();

    // Stall: 4 beats with out_ready low for 3 clocks
    load_addr('0);
    rdy_mode = 2;
    @(negedge clk);
    n_acc = 0;
    fork
      for (int i = 1; i <= 4; i++) send_m(4'd1, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i));
      begin
        repeat (3) @(negedge clk);
        #2;
        chk_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk_eq("stall_accepted", 32'(n_acc), 32'd2);
        rdy_mode = 0;
      end
    join
    drain();

    // Out-of-range ADDI immediate, then a legal beat
    send(4'd1, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd2048, 32'h00000013, 1'b1);
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    drain();
    chk_eq("err_flag_set", 32'(bus.err_flag), 32'd1);
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0; m_err = 1'b0; #2;
    chk_eq("err_flag_clr", 32'(bus.err_flag), 32'd0);

    // Counter wrap with unaligned base
    load_addr(16'hFFFF);
    send_m(4'd0, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'hFFFFFFFC);
    send_m(4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd9, 32'd36);
    drain();

    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      k = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      case ($urandom_range(0, 5))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = 32'($urandom_range(0, 40)) - 32'd4;
        2: imm = $urandom & 32'hFFFFF000;
        3: imm = 32'($urandom_range(0, 8200)) - 32'd4100;
        4: imm = 32'($urandom_range(0, 2097160)) - 32'd1048580;
        default: imm = $urandom;
      endcase
      send_m(k, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom),
             5'($urandom), imm);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    drain();
    chk_eq("rand_err_flag", 32'(bus.err_flag), 32'(m_err));

    // Asynchronous reset with beats in flight
    rdy_mode = 2;
    @(negedge clk);
    send_m(4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7);
    send_m(4'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd8);
    @(negedge clk); bus.in_valid = 1'b0;
    @(posedge clk); #3;
    chk_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    sbq.delete(); m_cnt = '0; m_err = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    rdy_mode = 1;
    send_m(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
